// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard sequencer: state encoding, control bundle and the
// canned control patterns the sequencer chooses between.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REFILL   = 2'd2,
    MEM_WAIT = 2'd3
  } hazard_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
  } hazard_ctrl_t;

  // Bit order follows the struct: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en
  localparam hazard_ctrl_t CTRL_ADVANCE      = 6'b110101;
  localparam hazard_ctrl_t CTRL_REDIRECT     = 6'b111111;
  localparam hazard_ctrl_t CTRL_LOAD_USE     = 6'b000111;
  localparam hazard_ctrl_t CTRL_FETCH_BUBBLE = 6'b011101;
  localparam hazard_ctrl_t CTRL_FREEZE       = 6'b000000;
  localparam hazard_ctrl_t CTRL_RESET        = 6'b001010;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use compare between the ID source registers and the EX load
// destination; x0 never produces a hazard.
module load_use_detector
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  input  logic                      uses_rs1,
  input  logic                      uses_rs2,
  input  logic                      mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic                      load_use
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_nonzero = (rd_addr != '0);
  assign rs1_hit    = uses_rs1 && (rs1_addr == rd_addr);
  assign rs2_hit    = uses_rs2 && (rs2_addr == rd_addr);
  assign load_use   = mem_read && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core. Optional perf counters are built
// only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_uses_rs1_i,
  input  logic                      id_uses_rs2_i,
  input  logic                      ex_MemRead_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic                      ex_redirect_i,
  input  logic                      imem_ready_i,
  input  logic                      dmem_busy_i,
  output logic                      pc_en_o,
  output logic                      if_id_en_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_en_o,
  output logic                      id_ex_flush_o,
  output logic                      ex_mem_en_o,
  output logic [1:0]                state_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  hazard_state_e state_q;
  hazard_state_e state_d;
  hazard_ctrl_t  ctrl;
  hazard_ctrl_t  ctrl_out;
  logic          load_use;
  logic          lu_allowed;

  load_use_detector u_load_use_detector (
    .rs1_addr (id_rs1_addr_i),
    .rs2_addr (id_rs2_addr_i),
    .uses_rs1 (id_uses_rs1_i),
    .uses_rs2 (id_uses_rs2_i),
    .mem_read (ex_MemRead_i),
    .rd_addr  (ex_rd_addr_i),
    .load_use (load_use)
  );

  // MEM_WAIT releases under RUN rules; LU_STALL and REFILL mask detection
  assign lu_allowed = (state_q == RUN) || (state_q == MEM_WAIT);

  always_comb begin
    ctrl    = CTRL_ADVANCE;
    state_d = RUN;
    if (dmem_busy_i) begin
      ctrl    = CTRL_FREEZE;
      state_d = MEM_WAIT;
    end else if (ex_redirect_i) begin
      ctrl    = CTRL_REDIRECT;
      state_d = imem_ready_i ? RUN : REFILL;
    end else if (load_use && lu_allowed) begin
      ctrl    = CTRL_LOAD_USE;
      state_d = LU_STALL;
    end else if (!imem_ready_i) begin
      ctrl    = CTRL_FETCH_BUBBLE;
      state_d = (state_q == REFILL) ? REFILL : RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctrl_out      = rst ? CTRL_RESET : ctrl;
  assign pc_en_o       = ctrl_out.pc_en;
  assign if_id_en_o    = ctrl_out.if_id_en;
  assign if_id_flush_o = ctrl_out.if_id_flush;
  assign id_ex_en_o    = ctrl_out.id_ex_en;
  assign id_ex_flush_o = ctrl_out.id_ex_flush;
  assign ex_mem_en_o   = ctrl_out.ex_mem_en;
  assign state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ctrl_out.pc_en) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (ex_redirect_i && !dmem_busy_i) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, reset-in-freeze sequence,
// then randomized traffic against a flag-based behavioural model.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1_addr = '0;
  logic [4:0]  id_rs2_addr = '0;
  logic        id_uses_rs1 = 1'b0;
  logic        id_uses_rs2 = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd_addr = '0;
  logic        ex_redirect = 1'b0;
  logic        imem_ready = 1'b1;
  logic        dmem_busy = 1'b0;
  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic [1:0]  state;
  logic [31:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pipeline_hazard_ctrl #(.CNT_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1_addr_i (id_rs1_addr),
    .id_rs2_addr_i (id_rs2_addr),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_MemRead_i  (ex_mem_read),
    .ex_rd_addr_i  (ex_rd_addr),
    .ex_redirect_i (ex_redirect),
    .imem_ready_i  (imem_ready),
    .dmem_busy_i   (dmem_busy),
    .pc_en_o       (pc_en),
    .if_id_en_o    (if_id_en),
    .if_id_flush_o (if_id_flush),
    .id_ex_en_o    (id_ex_en),
    .id_ex_flush_o (id_ex_flush),
    .ex_mem_en_o   (ex_mem_en),
    .state_o       (state),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2, mr;
    logic [4:0] rd;
    logic       redir, ready, busy;
    logic [5:0] exp_ctrl;
    logic [1:0] exp_state;
  } vec_t;

  vec_t tbl[$];

  localparam logic [5:0] ADV = 6'b110101;
  localparam logic [5:0] RDR = 6'b111111;
  localparam logic [5:0] LUS = 6'b000111;
  localparam logic [5:0] FBB = 6'b011101;
  localparam logic [5:0] FRZ = 6'b000000;
  localparam logic [5:0] RSO = 6'b001010;

  function automatic vec_t mk(input int rs1, rs2, u1, u2, mr, rd, redir, ready, busy,
                              input logic [5:0] ec, input int es);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2); v.mr = 1'(mr);
    v.rd = 5'(rd); v.redir = 1'(redir); v.ready = 1'(ready); v.busy = 1'(busy);
    v.exp_ctrl = ec; v.exp_state = 2'(es);
    return v;
  endfunction

  function automatic logic [5:0] ctrl_vec();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, rs2, input logic u1, u2, mr,
                       input logic [4:0] rd, input logic redir, ready, busy);
    @(negedge clk);
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_mem_read = mr; ex_rd_addr = rd; ex_redirect = redir; imem_ready = ready;
    dmem_busy = busy;
    #2;
  endtask

  // Behavioural model: flags describing what the pipeline is currently doing
  logic        m_wait, m_mask, m_refill;
  logic [31:0] m_stall, m_flush;

  initial begin
    for (int i = 0; i < 2; i++) @(negedge clk);
    #2;
    chk("reset_ctrl", 32'(ctrl_vec()), 32'(RSO));
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall_cnt", stall_cnt, 32'd0);
    chk("reset_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk(5,0,1,0,1,5,0,1,0, LUS, 0));  // load-use on rs1
    tbl.push_back(mk(5,0,1,0,1,5,0,1,0, ADV, 1));  // masked: one bubble only
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, ADV, 0));
    tbl.push_back(mk(0,0,1,0,1,0,0,1,0, ADV, 0));  // x0 destination
    tbl.push_back(mk(3,7,0,1,1,7,0,1,0, LUS, 0));  // load-use on rs2
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, ADV, 1));
    tbl.push_back(mk(7,0,0,0,1,7,0,1,0, ADV, 0));  // match but rs1 unused
    tbl.push_back(mk(5,0,1,0,1,5,1,1,0, RDR, 0));  // redirect beats load-use
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, ADV, 0));
    tbl.push_back(mk(0,0,0,0,0,0,1,0,0, RDR, 0));  // redirect, fetch not ready
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, FBB, 2));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, FBB, 2));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, FBB, 2));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, ADV, 2));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, ADV, 0));
    tbl.push_back(mk(0,0,0,0,0,0,1,1,1, FRZ, 0));  // freeze with redirect held
    tbl.push_back(mk(0,0,0,0,0,0,1,1,1, FRZ, 3));
    tbl.push_back(mk(0,0,0,0,0,0,1,1,1, FRZ, 3));
    tbl.push_back(mk(0,0,0,0,0,0,1,1,1, FRZ, 3));
    tbl.push_back(mk(0,0,0,0,0,0,1,1,0, RDR, 3));  // redirect applied on release
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, ADV, 0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0, FBB, 0));  // fetch miss in RUN
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0, ADV, 0));
    tbl.push_back(mk(4,0,1,0,1,4,0,1,1, FRZ, 0));
    tbl.push_back(mk(4,0,1,0,1,4,0,1,0, LUS, 3));  // load-use detected on release
    tbl.push_back(mk(4,0,1,0,1,4,0,1,0, ADV, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].mr, tbl[i].rd,
            tbl[i].redir, tbl[i].ready, tbl[i].busy);
      chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_vec()), 32'(tbl[i].exp_ctrl));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
    end

    // Reset in the middle of a memory freeze
    drive(0,0,0,0,0,0,0,1,1);
    drive(0,0,0,0,0,0,0,1,1);
    chk("freeze_state", 32'(state), 32'd3);
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", 32'(ctrl_vec()), 32'(RSO));
    chk("rst_mid_state", 32'(state), 32'd0);
    drive(0,0,0,0,0,0,0,1,1);
    chk("rst_hold_ctrl", 32'(ctrl_vec()), 32'(RSO));
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dmem_busy = 1'b0;
    #2;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_ctrl", 32'(ctrl_vec()), 32'(ADV));
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);

    m_wait = 1'b0; m_mask = 1'b0; m_refill = 1'b0;
    m_stall = '0; m_flush = '0;

    for (int i = 0; i < 600; i++) begin
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, mr, redir, ready, busy, lu, lu_eff;
      logic [5:0] exp_ctrl;
      logic [1:0] exp_state;
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1 = 1'($urandom_range(0, 1)); u2 = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      redir = ($urandom_range(0, 5) == 0);
      ready = ($urandom_range(0, 4) != 0);
      busy  = ($urandom_range(0, 6) == 0);
      drive(rs1, rs2, u1, u2, mr, rd, redir, ready, busy);

      lu     = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      lu_eff = lu && !busy && !redir && !m_mask && !m_refill;
      exp_ctrl = { !busy && (redir || (!lu_eff && ready)),
                   !busy && !lu_eff,
                   !busy && (redir || (!lu_eff && !ready)),
                   !busy,
                   !busy && (redir || lu_eff),
                   !busy };
      exp_state = m_wait ? 2'd3 : m_mask ? 2'd1 : m_refill ? 2'd2 : 2'd0;

      chk($sformatf("rnd%0d_ctrl", i), 32'(ctrl_vec()), 32'(exp_ctrl));
      chk($sformatf("rnd%0d_state", i), 32'(state), 32'(exp_state));
`ifdef HAZARD_PERF_CNT_EN
      chk($sformatf("rnd%0d_stall_cnt", i), stall_cnt, m_stall);
      chk($sformatf("rnd%0d_flush_cnt", i), flush_cnt, m_flush);
`endif

      if (!exp_ctrl[5]) m_stall++;
      if (redir && !busy) m_flush++;
      if (busy) begin
        m_wait = 1'b1; m_mask = 1'b0; m_refill = 1'b0;
      end else begin
        m_wait   = 1'b0;
        m_mask   = lu_eff;
        m_refill = !ready && (redir || m_refill);
      end
    end

    @(negedge clk);
    #2;
`ifdef HAZARD_PERF_CNT_EN
    chk("final_stall_cnt", stall_cnt, m_stall);
    chk("final_flush_cnt", flush_cnt, m_flush);
`else
    chk("final_stall_cnt_tied", stall_cnt, 32'd0);
    chk("final_flush_cnt_tied", flush_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
